uart_sdram_loader: RTL and testbench

Loader stage between the UART receiver and the SDRAM controller. It pairs received bytes into 16-bit little-endian words and issues one SDRAM write per word at consecutive addresses starting from 0. A byte-gap timeout recovers framing, and an overrun flag reports words that arrive while the previous write is still outstanding. It is active only while `load_en` is high (program-load mode).

---
 rtl/lc_load_pkg.sv | 10 +
 rtl/uart_byte_pair.sv | 68 ++++++
 rtl/uart_sdram_loader.sv | 110 +++++++++++
 tb/tb_uart_sdram_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc_load_pkg.sv
// Shared types and constants for the UART-to-SDRAM program loader.
package lc_load_pkg;

    typedef enum logic {LOW, HIGH} asm_state_t;

    typedef enum logic {WR_IDLE, WR_PEND} wr_state_t;

    localparam int WORD_W = 16;

endpackage

// File: rtl/uart_byte_pair.sv
// Pairs UART bytes into little-endian 16-bit words, with a byte-gap timeout.
// word_valid/word are combinational, so the top can register a request on
// the same edge that samples the high byte.
module uart_byte_pair
    import lc_load_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic              half_word
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    asm_state_t       state, state_nxt;
    logic [7:0]       low_q;
    logic [CNT_W-1:0] gap_cnt;

    // State register, low-byte latch and saturating byte-gap counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOW;
            low_q   <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_en && state == LOW && byte_valid)
                low_q <= byte_in;
            if (!load_en || byte_valid || state == LOW)
                gap_cnt <= '0;
            else if (gap_cnt != CNT_MAX)
                gap_cnt <= gap_cnt + CNT_W'(1);
        end
    end

    // Next state and word strobe; a byte in the expiry cycle still wins
    always_comb begin
        state_nxt  = state;
        word_valid = 1'b0;
        case (state)
            LOW: if (byte_valid) state_nxt = HIGH;
            HIGH: begin
                if (byte_valid) begin
                    word_valid = 1'b1;
                    state_nxt  = LOW;
                end else if (gap_cnt == CNT_MAX) begin
                    state_nxt = LOW;
                end
            end
            default: state_nxt = LOW;
        endcase
        if (!load_en) begin
            state_nxt  = LOW;
            word_valid = 1'b0;
        end
    end

    assign word      = {byte_in, low_q};
    assign half_word = (state == HIGH);

endmodule

// File: rtl/uart_sdram_loader.sv
// Loader between UART receiver and SDRAM controller: one write per assembled
// word at consecutive addresses, with sticky overrun and address-full flags.
module uart_sdram_loader
    import lc_load_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] word_count,
    output logic              half_word,
    output logic              overrun,
    output logic              full
);

    logic              word_valid;
    logic [WORD_W-1:0] word;

    wr_state_t         wr_state, wr_nxt;
    logic              load_en_q;
    logic              ack_take, wrap, load_word, set_ovr;
    logic [ADDR_W-1:0] count_inc, load_addr;

    uart_byte_pair #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_pair (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .word_valid(word_valid),
        .word      (word),
        .half_word (half_word)
    );

    assign count_inc = word_count + ADDR_W'(1);
    assign ack_take  = (wr_state == WR_PEND) && wr_ack;
    // The ack that wraps the address space also blocks a coincident word,
    // otherwise it would land on address 0 of a full load.
    assign wrap      = ack_take && (word_count == '1);

    // Write FSM next state, word load and overrun detection
    always_comb begin
        wr_nxt    = wr_state;
        load_word = 1'b0;
        load_addr = word_count;
        set_ovr   = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (word_valid && !full) begin
                    load_word = 1'b1;
                    wr_nxt    = WR_PEND;
                end
            end
            WR_PEND: begin
                if (wr_ack) begin
                    wr_nxt = WR_IDLE;
                    if (word_valid && !full && !wrap) begin
                        load_word = 1'b1;
                        load_addr = count_inc;
                        wr_nxt    = WR_PEND;
                    end
                end else if (word_valid && !full) begin
                    set_ovr = 1'b1;
                end
            end
            default: wr_nxt = WR_IDLE;
        endcase
    end

    // Write state, request payload, count and sticky flags; load_en rise restarts the load
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state   <= WR_IDLE;
            load_en_q  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            word_count <= '0;
            overrun    <= 1'b0;
            full       <= 1'b0;
        end else begin
            wr_state  <= wr_nxt;
            load_en_q <= load_en;
            if (load_word) begin
                wr_addr <= load_addr;
                wr_data <= word;
            end
            if (ack_take) word_count <= count_inc;
            if (wrap)     full       <= 1'b1;
            if (set_ovr)  overrun    <= 1'b1;
            if (load_en && !load_en_q) begin
                word_count <= '0;
                overrun    <= 1'b0;
                full       <= 1'b0;
            end
        end
    end

    assign wr_req = (wr_state == WR_PEND);

endmodule

// File: tb/tb_uart_sdram_loader.sv
// Directed and randomized bench for uart_sdram_loader against a
// transaction-level reference model (ADDR_W=2, timeout 100).
module tb_uart_sdram_loader;

    localparam int AW = 2;
    localparam int T  = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic [7:0]    byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          wr_ack = 1'b0;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [AW-1:0] word_count;
    logic          half_word, overrun, full;

    int errors = 0;
    int checks = 0;

    // reference model state
    int          m_count;
    bit          m_full, m_ovr, m_pend, m_half, m_en_prev;
    int          m_gap;
    logic [7:0]  m_low;
    int          m_addr;
    logic [15:0] m_data;

    uart_sdram_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .word_count(word_count),
        .half_word (half_word),
        .overrun   (overrun),
        .full      (full)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wr_req"},     32'(wr_req),     32'(m_pend));
        chk({tag, ".word_count"}, 32'(word_count), 32'(m_count));
        chk({tag, ".half_word"},  32'(half_word),  32'(m_half));
        chk({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
        chk({tag, ".full"},       32'(full),       32'(m_full));
        if (m_pend) begin
            chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(m_addr));
            chk({tag, ".wr_data"}, 32'(wr_data), 32'(m_data));
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_full = 0; m_ovr = 0; m_pend = 0; m_half = 0;
        m_en_prev = 0; m_gap = 0; m_low = '0; m_addr = 0; m_data = '0;
    endtask

    // One clock edge as seen by the spec rules, given the sampled inputs
    task automatic model_edge(input bit en, input bit bv, input logic [7:0] b, input bit ack);
        bit          done;
        logic [15:0] w;
        done = 0;
        w    = '0;
        if (!en) begin
            m_half = 0;
            m_gap  = 0;
        end else if (bv) begin
            if (m_half) begin
                done   = 1;
                w      = {b, m_low};
                m_half = 0;
            end else begin
                m_half = 1;
                m_low  = b;
                m_gap  = 0;
            end
        end else if (m_half) begin
            if (m_gap == T) m_half = 0;
            else m_gap++;
        end
        if (ack && m_pend) begin
            m_pend  = 0;
            m_count = (m_count + 1) % (1 << AW);
            if (m_count == 0) m_full = 1;
        end
        if (done && !m_full) begin
            if (m_pend) m_ovr = 1;
            else begin
                m_pend = 1;
                m_addr = m_count;
                m_data = w;
            end
        end
        if (en && !m_en_prev) begin
            m_count = 0;
            m_ovr   = 0;
            m_full  = 0;
        end
        m_en_prev = en;
    endtask

    task automatic step(input bit bv, input logic [7:0] b, input bit ack, input string tag);
        byte_in    = b;
        byte_valid = bv;
        wr_ack     = ack;
        @(posedge clk);
        model_edge(load_en, bv, b, ack);
        #1;
        byte_valid = 1'b0;
        wr_ack     = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, tag);
    endtask

    task automatic toggle_en(input string tag);
        load_en = 1'b0;
        step(1'b1, 8'h5A, 1'b0, {tag, ".low"});
        step(1'b1, 8'hA5, 1'b0, {tag, ".low2"});
        load_en = 1'b1;
        step(1'b0, 8'h00, 1'b0, {tag, ".rise"});
    endtask

    initial begin
        int r;
        model_reset();
        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset");
        chk("reset.wr_addr", 32'(wr_addr), 32'd0);
        chk("reset.wr_data", 32'(wr_data), 32'd0);
        load_en = 1'b1;
        step(1'b0, 8'h00, 1'b0, "en_rise");

        // first word, ack three cycles after the request
        step(1'b1, 8'hAB, 1'b0, "w0.lo");
        step(1'b1, 8'hCD, 1'b0, "w0.hi");
        chk("w0.data_const", 32'(wr_data), 32'h0000CDAB);
        idle(2, "w0.wait");
        step(1'b0, 8'h00, 1'b1, "w0.ack");
        chk("w0.count_const", 32'(word_count), 32'd1);

        // second word
        step(1'b1, 8'h25, 1'b0, "w1.lo");
        step(1'b1, 8'h98, 1'b0, "w1.hi");
        step(1'b0, 8'h00, 1'b1, "w1.ack");
        step(1'b0, 8'h00, 1'b1, "stray_ack");

        // timeout expiry drops the low byte
        step(1'b1, 8'h11, 1'b0, "to.lo");
        idle(T, "to.wait");
        chk("to.half_before", 32'(half_word), 32'd1);
        step(1'b0, 8'h00, 1'b0, "to.expire");
        chk("to.half_after", 32'(half_word), 32'd0);
        step(1'b1, 8'h22, 1'b0, "to.w.lo");
        step(1'b1, 8'h33, 1'b0, "to.w.hi");
        chk("to.data_const", 32'(wr_data), 32'h00003322);
        step(1'b0, 8'h00, 1'b1, "to.ack");

        // byte arriving in the expiry cycle still completes the word
        toggle_en("tgl0");
        step(1'b1, 8'h44, 1'b0, "exp.lo");
        idle(T, "exp.wait");
        step(1'b1, 8'h55, 1'b0, "exp.hi");
        chk("exp.data_const", 32'(wr_data), 32'h00005544);
        step(1'b0, 8'h00, 1'b1, "exp.ack");

        // overrun, then back-to-back load with coincident ack
        toggle_en("tgl1");
        step(1'b1, 8'h01, 1'b0, "ov.a.lo");
        step(1'b1, 8'h02, 1'b0, "ov.a.hi");
        step(1'b1, 8'h03, 1'b0, "ov.b.lo");
        step(1'b1, 8'h04, 1'b0, "ov.b.hi");
        chk("ov.flag_const", 32'(overrun), 32'd1);
        step(1'b1, 8'h05, 1'b0, "b2b.lo");
        step(1'b1, 8'h06, 1'b1, "b2b.hi");
        chk("b2b.addr_const", 32'(wr_addr), 32'd1);
        step(1'b0, 8'h00, 1'b1, "b2b.ack");

        // address exhaustion
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'(i + 8'h10), 1'b0, "fill.lo");
            step(1'b1, 8'(i + 8'h20), 1'b0, "fill.hi");
            step(1'b0, 8'h00, 1'b1, "fill.ack");
        end
        chk("full.flag_const", 32'(full), 32'd1);
        step(1'b1, 8'h77, 1'b0, "full.lo");
        step(1'b1, 8'h88, 1'b0, "full.hi");
        chk("full.noreq_const", 32'(wr_req), 32'd0);
        toggle_en("tgl2");
        chk("full.cleared", 32'(full), 32'd0);

        // reset while a write is pending and a low byte is held
        step(1'b1, 8'h61, 1'b0, "rst.w.lo");
        step(1'b1, 8'h62, 1'b0, "rst.w.hi");
        step(1'b1, 8'h63, 1'b0, "rst.lo");
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        check_all("rst");
        chk("rst.wr_addr", 32'(wr_addr), 32'd0);
        chk("rst.wr_data", 32'(wr_data), 32'd0);
        step(1'b0, 8'h00, 1'b0, "rst.rise");
        step(1'b1, 8'h71, 1'b0, "rst.p.lo");
        step(1'b1, 8'h72, 1'b0, "rst.p.hi");
        chk("rst.addr0", 32'(wr_addr), 32'd0);
        step(1'b0, 8'h00, 1'b1, "rst.p.ack");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 19);
            if (r < 9)       step(1'b1, 8'($urandom), 1'b0, "rnd.byte");
            else if (r < 13) step(1'b0, 8'h00, 1'b1, "rnd.ack");
            else if (r < 15) step(1'b1, 8'($urandom), 1'b1, "rnd.byte_ack");
            else if (r < 18) idle($urandom_range(1, 5), "rnd.idle");
            else if (r < 19) idle($urandom_range(T - 3, T + 3), "rnd.long");
            else             toggle_en("rnd.tgl");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
